adder_arb_4ch: RTL and testbench
================================

ADDER_ARB_4CH -- requirements
Module: adder_arb_4ch

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-transaction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  4  per-channel request; channel i = bit i.
REQ-005 req_a  input  128  operand A; channel i on bits [32i+31:32i].
REQ-006 req_b  input  128  operand B; same packing as req_a.
REQ-007 req_ready  output  4  grant/accept strobe, at most one bit high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  2  channel that owns the result.
REQ-011 rsp_sum  output  32  A+B mod 2^32.
REQ-012 rsp_cout  output  1  carry out of bit 31.
REQ-013 txn_cnt  output  CNT_W  completed responses, wraps modulo 2^CNT_W.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Exactly one adder_32bit instance (carry-in fixed 0) SHALL be shared by all four channels; the sum comes from it, never from a behavioural "+".
REQ-016 FSM states SHALL be IDLE, CALC and RESP, and reset SHALL force IDLE.
REQ-017 IDLE, no req_valid bit set: req_ready = 0; remain in IDLE.
REQ-018 IDLE, any req_valid bit set: the winner is chosen round-robin starting at pointer ptr, searching ptr, ptr+1, ... mod 4.
REQ-019 The winner's req_ready bit SHALL be high combinationally in that same IDLE cycle.
REQ-020 On that clock edge: capture the winner's req_a/req_b into operand registers, capture its index into rsp_id, go to CALC.
REQ-021 CALC lasts exactly one cycle; it registers the adder outputs into rsp_sum/rsp_cout, then goes to RESP.
REQ-022 RESP: rsp_valid = 1; rsp_id/rsp_sum/rsp_cout SHALL stay stable until rsp_ready is sampled high.
REQ-023 On the rsp_valid&rsp_ready edge: ptr <= rsp_id+1 (mod 4, 3 wraps to 0), txn_cnt increments, go to IDLE.
REQ-024 Latency: a grant in cycle T gives rsp_valid first high in cycle T+2; with rsp_ready held high, the minimum request-to-request period is 3 cycles.
REQ-025 req_ready SHALL be 0 in CALC and RESP; requests are ignored there and are not queued.
REQ-026 A requester may drop req_valid before it is granted with no side effect; after the grant its inputs are don't-care.
REQ-027 Operand changes on any channel after capture SHALL NOT affect the in-flight result.
REQ-028 Overflow: the carry appears only on rsp_cout; rsp_sum wraps.
REQ-029 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-030 While rst is high, asynchronously: state = IDLE, ptr = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, txn_cnt = 0, busy = 0.
REQ-031 Reset during CALC or RESP SHALL discard the in-flight transaction without counting it; the first edge after rst falls evaluates IDLE normally.

Verification
REQ-032 Single request: channel 2 sends A=0x0000_0005, B=0x0000_0003 -> req_ready=4'b0100 in cycle T; rsp_valid in T+2 with sum=0x0000_0008, cout=0, id=2; txn_cnt=1 after the accept.
REQ-033 Overflow: A=0xFFFF_FFFF, B=0x0000_0001 -> sum=0x0000_0000, cout=1; A=B=0x8000_0000 -> sum=0, cout=1.
REQ-034 Fairness: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,... with one grant every 3 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* held constant, req_ready=0, no new grant; rsp_ready=1 -> return to IDLE next cycle.
REQ-036 Reset mid-op: assert rst in CALC -> all outputs 0 immediately; txn_cnt unchanged at 0; after release, channel 1 alone -> granted, id=1.
REQ-037 Counter wrap: with CNT_W=4, 17 transactions -> txn_cnt=1.

Source files
------------

// File: rtl/adder_arb_4ch.sv
// Four-channel round-robin arbiter sharing one 32-bit ripple-carry adder.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.

module adder_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [32:0] w_c;

  assign w_c[0] = i_cin;

  genvar g;
  generate
    for (g = 0; g < 32; g++) begin : g_fa
      assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
  endgenerate

  assign o_cout = w_c[32];
endmodule

module adder_arb_4ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [127:0]     req_a,
  input  logic [127:0]     req_b,
  output logic [3:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_id,
  output logic [31:0]      rsp_sum,
  output logic             rsp_cout,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_ptr;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [1:0]       r_id;
  logic [31:0]      r_sum;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_idx;
  logic             w_found;
  logic [1:0]       w_cand;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic [31:0]      w_add_sum;
  logic             w_add_cout;
  logic             w_take;
  logic             w_done;

  // Scan from ptr+3 down to ptr so the channel closest to ptr wins last.
  always_comb begin
    w_idx   = 2'd0;
    w_found = 1'b0;
    w_cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req_valid[w_cand]) begin
        w_idx   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_sel_a = req_a[{w_idx, 5'b00000} +: 32];
  assign w_sel_b = req_b[{w_idx, 5'b00000} +: 32];

  assign w_take = (r_state == ST_IDLE) && w_found;
  assign w_done = (r_state == ST_RESP) && rsp_ready;

  adder_32bit u_adder (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (1'b0),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next = ST_CALC;
      ST_CALC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_op_a  <= 32'd0;
      r_op_b  <= 32'd0;
      r_id    <= 2'd0;
      r_sum   <= 32'd0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_id   <= w_idx;
      end
      if (r_state == ST_CALC) begin
        r_sum  <= w_add_sum;
        r_cout <= w_add_cout;
      end
      if (w_done) begin
        r_ptr <= r_id + 2'd1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Grant is gated by rst so it drops at once when reset is asserted.
  assign req_ready = (w_take && !rst) ? (4'b0001 << w_idx) : 4'b0000;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign txn_cnt   = r_cnt;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_adder_arb_4ch.sv
// Randomized bench for adder_arb_4ch with a transaction-level reference model.
// A second instance with a 4-bit counter shares the stimulus to exercise wrap.

module tb_adder_arb_4ch;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_ready;
  logic [3:0]   req_ready,  req_ready4;
  logic         rsp_valid,  rsp_valid4;
  logic [1:0]   rsp_id,     rsp_id4;
  logic [31:0]  rsp_sum,    rsp_sum4;
  logic         rsp_cout,   rsp_cout4;
  logic [15:0]  txn_cnt;
  logic [3:0]   txn_cnt4;
  logic         busy,       busy4;
  logic [1:0]   dbg_state,  dbg_state4;

  adder_arb_4ch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .txn_cnt(txn_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  adder_arb_4ch #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id4), .rsp_sum(rsp_sum4), .rsp_cout(rsp_cout4),
    .txn_cnt(txn_cnt4), .busy(busy4), .dbg_state(dbg_state4)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [31:0] t_a [4];
  logic [31:0] t_b [4];
  logic [34:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = t_a[i];
      req_b[32*i +: 32] = t_b[i];
    end
  endtask

  task automatic scramble();
    req_valid = 4'($urandom);
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       t_a[i] = 32'hFFFF_FFFF;
        1:       t_a[i] = 32'h8000_0000;
        default: t_a[i] = $urandom;
      endcase
      t_b[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
    end
  endtask

  // Called just after a falling edge with the DUT idle; returns in the same position.
  task automatic do_txn(input logic [3:0] mask, input int stall);
    int          w;
    logic [32:0] s;
    logic [3:0]  g;
    logic [34:0] e;
    req_valid = mask;
    drive_ops();
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    w = pick(mask, m_ptr);
    g = (w < 0) ? 4'b0000 : (4'b0001 << w);
    check("grant", req_ready, g);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    if (w < 0) begin
      @(posedge clk); @(negedge clk);
      return;
    end
    s = {1'b0, t_a[w]} + {1'b0, t_b[w]};
    e = {2'(w), s};
    exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    scramble();
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    check("calc_ready", req_ready, 0);
    check("calc_busy", busy, 1);
    check("calc_rsp_valid", rsp_valid, 0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      scramble();
      #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_ready", req_ready, 0);
      check("stall_rsp", {rsp_id, rsp_cout, rsp_sum}, exp_q[0]);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    scramble();
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_ready_grant", req_ready, 0);
    check("rsp", {rsp_id, rsp_cout, rsp_sum}, exp_q.pop_front());
    @(posedge clk);
    m_ptr = (w + 1) % 4;
    m_cnt++;
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    check("back_idle", busy, 0);
    check("txn_cnt", txn_cnt, m_cnt % 65536);
    check("txn_cnt4", txn_cnt4, m_cnt % 16);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin t_a[i] = 32'd0; t_b[i] = 32'd0; end
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_outs", {rsp_valid, rsp_id, rsp_cout, rsp_sum, busy}, 0);
    check("rst_cnt", txn_cnt, 0);
    check("rst_cnt4", txn_cnt4, 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;

    // Reset while the adder stage is active discards the transaction.
    t_a[3] = 32'h1234_5678; t_b[3] = 32'h1111_1111;
    req_valid = 4'b1000;
    drive_ops();
    #1;
    check("pre_rst_grant", req_ready, 4'b1000);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_busy", busy, 0);
    check("midop_outs", {req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
    check("midop_cnt", txn_cnt, 0);
    m_ptr = 0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
    t_a[1] = 32'h0000_00AA; t_b[1] = 32'h0000_0055;
    do_txn(4'b0010, 0);

    t_a[2] = 32'h0000_0005; t_b[2] = 32'h0000_0003;
    do_txn(4'b0100, 0);
    t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'h0000_0001;
    do_txn(4'b0001, 1);
    t_a[3] = 32'h8000_0000; t_b[3] = 32'h8000_0000;
    do_txn(4'b1000, 0);

    // Fairness: everyone requesting continuously.
    rand_ops();
    for (int i = 0; i < 8; i++) do_txn(4'b1111, 0);

    rand_ops();
    do_txn(4'b0110, 5);
    do_txn(4'b0000, 0);
    do_txn(4'b0000, 0);

    for (int i = 0; i < 30; i++) begin
      rand_ops();
      do_txn(4'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
